// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : N-master shared-bus arbiter. Grants exclusive ownership of the
//            bus to at most one master, with fixed-priority or round-robin
//            selection, a mandatory all-zero turnaround cycle after every
//            release, and a stall watchdog that revokes a stuck owner.
// Ports    : clk          - rising-edge clock
//            reset        - synchronous, active-low
//            Bus_RQ       - per-master level-held request
//            Bus_Ready    - memory completion/ready strobe
//            Bus_GRANT    - registered one-hot (or zero) grant
//            Grant_Id     - index of current/last owner
//            Bus_Busy     - high in GRANT or RELEASE
//            Timeout_Err  - one-cycle pulse on watchdog revoke
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int MODE           = 1,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ID_W           = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] Bus_RQ,
  input  logic                 Bus_Ready,
  output logic [N_MASTERS-1:0] Bus_GRANT,
  output logic [ID_W-1:0]      Grant_Id,
  output logic                 Bus_Busy,
  output logic                 Timeout_Err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  // One extra bit so index sums can exceed N_MASTERS-1 before wrapping.
  localparam int SUM_W = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [N_MASTERS-1:0] grant_nxt;
  logic [ID_W-1:0]      id_nxt;
  logic                 busy_nxt;
  logic                 terr_nxt;
  logic [ID_W-1:0]      ptr, ptr_nxt;
  logic [N_MASTERS-1:0] mask, mask_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;

  logic [N_MASTERS-1:0] eff_rq;
  logic [ID_W-1:0]      base;
  logic [SUM_W-1:0]     cand;
  logic [ID_W-1:0]      winner;
  logic                 found;
  logic [SUM_W-1:0]     winner_inc;
  logic [ID_W-1:0]      winner_next_ptr;

  // Timed-out masters stay masked until they are seen with RQ low.
  assign eff_rq = Bus_RQ & ~mask;

  // Winner search: start at ptr (round-robin) or 0 (fixed priority) and
  // take the first requester, wrapping modulo N_MASTERS.
  always_comb begin
    base   = (MODE == 1) ? ptr : '0;
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand = {1'b0, base} + SUM_W'(k);
      if (cand >= SUM_W'(N_MASTERS)) begin
        cand = cand - SUM_W'(N_MASTERS);
      end
      if (!found && eff_rq[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  assign winner_inc      = {1'b0, winner} + SUM_W'(1);
  assign winner_next_ptr = (winner_inc == SUM_W'(N_MASTERS)) ? '0 : winner_inc[ID_W-1:0];

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    grant_nxt = '0;
    id_nxt    = Grant_Id;
    terr_nxt  = 1'b0;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    mask_nxt  = mask & Bus_RQ;

    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = {{(N_MASTERS-1){1'b0}}, 1'b1} << winner;
          id_nxt    = winner;
          ptr_nxt   = winner_next_ptr;
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // A request drop takes precedence over a coincident timeout.
        if (!Bus_RQ[Grant_Id]) begin
          state_nxt = RELEASE;
        end else if ((TIMEOUT_CYCLES != 0) && !Bus_Ready && (cnt == CNT_LAST)) begin
          state_nxt          = RELEASE;
          mask_nxt[Grant_Id] = 1'b1;
          terr_nxt           = 1'b1;
        end else begin
          grant_nxt = Bus_GRANT;
          cnt_nxt   = Bus_Ready ? '0 : cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      Bus_GRANT   <= '0;
      Grant_Id    <= '0;
      Bus_Busy    <= 1'b0;
      Timeout_Err <= 1'b0;
      ptr         <= '0;
      mask        <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      Bus_GRANT   <= grant_nxt;
      Grant_Id    <= id_nxt;
      Bus_Busy    <= busy_nxt;
      Timeout_Err <= terr_nxt;
      ptr         <= ptr_nxt;
      mask        <= mask_nxt;
      cnt         <= cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter. Instance 0 is round-robin
//            with a 16-cycle watchdog, instance 1 is fixed priority with a
//            4-cycle watchdog. Directed scenarios plus randomized traffic
//            checked against a transaction-level ownership model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rq   [2];
  logic       rdy  [2];
  logic [3:0] gnt  [2];
  logic [1:0] gid  [2];
  logic       busy [2];
  logic       terr [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_MASTERS(4), .MODE(1), .TIMEOUT_CYCLES(16)) u_rr (
    .clk(clk), .reset(reset), .Bus_RQ(rq[0]), .Bus_Ready(rdy[0]),
    .Bus_GRANT(gnt[0]), .Grant_Id(gid[0]), .Bus_Busy(busy[0]), .Timeout_Err(terr[0])
  );

  bus_arbiter #(.N_MASTERS(4), .MODE(0), .TIMEOUT_CYCLES(4)) u_fp (
    .clk(clk), .reset(reset), .Bus_RQ(rq[1]), .Bus_Ready(rdy[1]),
    .Bus_GRANT(gnt[1]), .Grant_Id(gid[1]), .Bus_Busy(busy[1]), .Timeout_Err(terr[1])
  );

  // Ownership model: phase 0 = bus free, 1 = owned, 2 = turnaround.
  int         m_phase [2];
  int         m_owner [2];
  int         m_ptr   [2];
  int         m_stall [2];
  int         m_id    [2];
  logic [3:0] m_mask  [2];
  logic       m_err   [2];

  task automatic model_step(input int d);
    int         mode, tmo, w, i;
    logic [3:0] cand, nm;
    mode = (d == 0) ? 1 : 0;
    tmo  = (d == 0) ? 16 : 4;
    if (!reset) begin
      m_phase[d] = 0; m_owner[d] = 0; m_ptr[d] = 0; m_stall[d] = 0;
      m_id[d] = 0; m_mask[d] = 4'b0000; m_err[d] = 1'b0;
      return;
    end
    nm       = m_mask[d] & rq[d];
    m_err[d] = 1'b0;
    if (m_phase[d] == 0) begin
      cand = rq[d] & ~m_mask[d];
      if (cand != 4'b0000) begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          i = (mode == 1) ? (m_ptr[d] + k) % 4 : k;
          if (w < 0 && cand[i]) w = i;
        end
        m_owner[d] = w; m_id[d] = w; m_ptr[d] = (w + 1) % 4;
        m_stall[d] = 0; m_phase[d] = 1;
      end
    end else if (m_phase[d] == 1) begin
      if (!rq[d][m_owner[d]]) begin
        m_phase[d] = 2;
      end else if (!rdy[d] && m_stall[d] == tmo - 1) begin
        m_phase[d] = 2;
        nm[m_owner[d]] = 1'b1;
        m_err[d] = 1'b1;
      end else begin
        m_stall[d] = rdy[d] ? 0 : m_stall[d] + 1;
      end
    end else begin
      m_phase[d] = 0;
    end
    m_mask[d] = nm;
  endtask

  // Advance one clock: the model consumes the inputs seen at this edge,
  // then outputs are sampled 1 time unit after the edge.
  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rq[0] = 4'b0000; rq[1] = 4'b0000;
    rdy[0] = 1'b0;   rdy[1] = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rq[0] = 4'b1111; rq[1] = 4'b1111;
    rdy[0] = 1'b0;   rdy[1] = 1'b0;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({gnt[d], gid[d], busy[d], terr[d]} !== 8'h00) begin
        fails++;
        $display("FAIL reset[%0d]: got gnt=%b id=%0d busy=%b err=%b, need all zero",
                 d, gnt[d], gid[d], busy[d], terr[d]);
      end
    end
    rq[0] = 4'b0000; rq[1] = 4'b0000;
    reset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    rq[0] = 4'b0001;
    step();
    tests++;
    if (gnt[0] !== 4'b0001 || gid[0] !== 2'd0 || busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL single_grant: got gnt=%b id=%0d busy=%b, need 0001/0/1", gnt[0], gid[0], busy[0]);
    end
    for (int i = 0; i < 4; i++) begin
      rdy[0] = (i == 2);
      step();
      tests++;
      if (gnt[0] !== 4'b0001 || terr[0] !== 1'b0) begin
        fails++;
        $display("FAIL single_hold%0d: got gnt=%b err=%b, need 0001/0", i, gnt[0], terr[0]);
      end
    end
    rdy[0] = 1'b0;
    rq[0]  = 4'b0000;
    step();
    tests++;
    if (gnt[0] !== 4'b0000 || busy[0] !== 1'b1 || terr[0] !== 1'b0) begin
      fails++;
      $display("FAIL single_release: got gnt=%b busy=%b err=%b, need 0000/1/0", gnt[0], busy[0], terr[0]);
    end
    step();
    tests++;
    if (gnt[0] !== 4'b0000 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL single_idle: got gnt=%b busy=%b, need 0000/0", gnt[0], busy[0]);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int gap;
    bit got;
    do_reset();
    rq[0]  = 4'b1111;
    rdy[0] = 1'b1;
    for (int g = 0; g < 5; g++) begin
      gap = 0; got = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        if (gnt[0] != 4'b0000) got = 1'b1;
        else begin gap++; step(); end
      end
      tests++;
      if (!got || gid[0] !== 2'(order[g]) || gnt[0] !== (4'b0001 << order[g])) begin
        fails++;
        $display("FAIL rr_order%0d: got gnt=%b id=%0d, need master %0d", g, gnt[0], gid[0], order[g]);
      end
      if (g > 0) begin
        tests++;
        if (gap < 2) begin
          fails++;
          $display("FAIL rr_gap%0d: got %0d zero cycles, need at least 2", g, gap);
        end
      end
      step(); step();
      rq[0][order[g]] = 1'b0;
      step();
      rq[0][order[g]] = 1'b1;
    end
    rdy[0] = 1'b0;
  endtask

  task automatic test_fixed_priority();
    bit got;
    do_reset();
    rq[1]  = 4'b1010;
    rdy[1] = 1'b1;
    for (int g = 0; g < 3; g++) begin
      got = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        if (gnt[1] != 4'b0000) got = 1'b1;
        else step();
      end
      tests++;
      if (!got || gnt[1] !== 4'b0010 || gid[1] !== 2'd1) begin
        fails++;
        $display("FAIL fixed_grant%0d: got gnt=%b id=%0d, need 0010/1", g, gnt[1], gid[1]);
      end
      step(); step();
      rq[1][1] = 1'b0;
      step();
      rq[1][1] = 1'b1;
    end
    rdy[1] = 1'b0;
  endtask

  task automatic test_watchdog();
    int high;
    bit done;
    do_reset();
    rdy[1] = 1'b0;
    rq[1]  = 4'b0100;
    step();
    tests++;
    if (gnt[1] !== 4'b0100) begin
      fails++;
      $display("FAIL wd_grant: got gnt=%b, need 0100", gnt[1]);
    end
    high = 1; done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      if (c == 0) rq[1][0] = 1'b1;
      step();
      if (gnt[1] == 4'b0100) high++;
      else done = 1'b1;
    end
    tests++;
    if (high != 4 || terr[1] !== 1'b1 || gnt[1] !== 4'b0000) begin
      fails++;
      $display("FAIL wd_revoke: got %0d grant cycles err=%b gnt=%b, need 4/1/0000", high, terr[1], gnt[1]);
    end
    step();
    tests++;
    if (terr[1] !== 1'b0 || gnt[1] !== 4'b0000) begin
      fails++;
      $display("FAIL wd_pulse: got err=%b gnt=%b, need 0/0000", terr[1], gnt[1]);
    end
    step();
    tests++;
    if (gnt[1] !== 4'b0001) begin
      fails++;
      $display("FAIL wd_other: got gnt=%b, need 0001", gnt[1]);
    end
    rq[1] = 4'b0100;
    for (int c = 0; c < 4; c++) step();
    tests++;
    if (gnt[1] !== 4'b0000 || busy[1] !== 1'b0) begin
      fails++;
      $display("FAIL wd_masked: got gnt=%b busy=%b, need 0000/0", gnt[1], busy[1]);
    end
    rq[1] = 4'b0000;
    step();
    rq[1] = 4'b0100;
    step();
    tests++;
    if (gnt[1] !== 4'b0100) begin
      fails++;
      $display("FAIL wd_unmask: got gnt=%b, need 0100", gnt[1]);
    end
    rq[1] = 4'b0000;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    rq[0]  = 4'b1000;
    rdy[0] = 1'b1;
    step();
    step();
    tests++;
    if (gnt[0] !== 4'b1000) begin
      fails++;
      $display("FAIL midrst_own: got gnt=%b, need 1000", gnt[0]);
    end
    reset = 1'b0;
    rq[0] = 4'b1111;
    step();
    tests++;
    if (gnt[0] !== 4'b0000 || gid[0] !== 2'd0 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL midrst_clear: got gnt=%b id=%0d busy=%b, need 0000/0/0", gnt[0], gid[0], busy[0]);
    end
    reset = 1'b1;
    step();
    tests++;
    if (gnt[0] !== 4'b0001 || gid[0] !== 2'd0) begin
      fails++;
      $display("FAIL midrst_ptr: got gnt=%b id=%0d, need 0001/0", gnt[0], gid[0]);
    end
    rq[0]  = 4'b0000;
    rdy[0] = 1'b0;
  endtask

  task automatic test_wrap_turnaround();
    int gap;
    bit got;
    do_reset();
    rq[0] = 4'b1000;
    step();
    rq[0] = 4'b1001;
    step();
    rq[0] = 4'b0001;
    step();
    gap = 0; got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (gnt[0] != 4'b0000) got = 1'b1;
      else begin gap++; step(); end
    end
    tests++;
    if (!got || gnt[0] !== 4'b0001 || gap != 2) begin
      fails++;
      $display("FAIL wrap: got gnt=%b after %0d zero cycles, need 0001 after 2", gnt[0], gap);
    end
    rq[0] = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] exp_g;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int d = 0; d < 2; d++) begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(0, 7) == 0) rq[d][b] = ~rq[d][b];
        end
      end
      rdy[0] = ($urandom_range(0, 19) == 0);
      rdy[1] = ($urandom_range(0, 5) == 0);
      step();
      for (int d = 0; d < 2; d++) begin
        exp_g = (m_phase[d] == 1) ? (4'b0001 << m_owner[d]) : 4'b0000;
        tests++;
        if (gnt[d] !== exp_g || gid[d] !== 2'(m_id[d]) ||
            busy[d] !== (m_phase[d] != 0) || terr[d] !== m_err[d]) begin
          fails++;
          $display("FAIL random[%0d] cyc %0d: got gnt=%b id=%0d busy=%b err=%b, need %b/%0d/%b/%b",
                   d, n, gnt[d], gid[d], busy[d], terr[d], exp_g, m_id[d], (m_phase[d] != 0), m_err[d]);
        end
        tests++;
        if ($countones(gnt[d]) > 1) begin
          fails++;
          $display("FAIL onehot[%0d] cyc %0d: got gnt=%b, need at most one bit", d, n, gnt[d]);
        end
      end
    end
  endtask

  initial begin
    rq[0] = 4'b0000; rq[1] = 4'b0000;
    rdy[0] = 1'b0;   rdy[1] = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_watchdog();
    test_reset_mid_grant();
    test_wrap_turnaround();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
